// File: rtl/regfile_pkg.sv
// Shared definitions for the controller's register-access interface.
package regfile_pkg;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/regfile_resp_if.sv
// Controller <-> register file access bus: address/cs/rw/memdatw/memdatr.
interface regfile_resp_if #(
  parameter int unsigned DW = regfile_pkg::DW,
  parameter int unsigned AW = regfile_pkg::AW
) ();

  logic          cs;
  logic          rw;
  logic [AW-1:0] address;
  logic [DW-1:0] memdatw;
  logic [DW-1:0] memdatr;

  modport master (
    output cs,
    output rw,
    output address,
    output memdatw,
    input  memdatr
  );

  modport slave (
    input  cs,
    input  rw,
    input  address,
    input  memdatw,
    output memdatr
  );

endinterface

// File: rtl/regfile_resp.sv
// General register file answering the controller's register bus, with a boot/load
// write port, a combinational debug read port and a committed-write counter.
module regfile_resp #(
  parameter int unsigned DW      = regfile_pkg::DW,
  parameter int unsigned AW      = regfile_pkg::AW,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  regfile_resp_if.slave bus,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic [7:0]    wr_cnt
);
  import regfile_pkg::*;

  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0] regs_q [Depth];
  logic [DW-1:0] regs_d [Depth];
  logic [DW-1:0] rd_q, rd_d;
  logic [7:0]    cnt_q, cnt_d;

  logic prot_rd, prot_wr, prot_commit, ld_commit;

  function automatic logic writable(logic [AW-1:0] idx);
    return !(ZERO_R0 && (idx == '0));
  endfunction

  assign prot_rd   = bus.cs && (bus.rw == RW_READ);
  assign prot_wr   = bus.cs && (bus.rw == RW_WRITE);
  assign ld_commit = ld_en && writable(ld_addr);
  // The load port owns the address on a collision, so the protocol write is dropped.
  assign prot_commit = prot_wr && writable(bus.address) &&
                       !(ld_en && (ld_addr == bus.address));

  always_comb begin
    regs_d = regs_q;
    if (prot_commit) regs_d[bus.address] = bus.memdatw;
    if (ld_commit)   regs_d[ld_addr]     = ld_data;
    // Read samples the pre-edge array: read-before-write against any same-edge write.
    rd_d = rd_q;
    if (prot_rd) begin
      rd_d = (ZERO_R0 && (bus.address == '0)) ? '0 : regs_q[bus.address];
    end
    cnt_d = cnt_q + {7'd0, prot_commit} + {7'd0, ld_commit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < Depth; i++) regs_q[i] <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.memdatr = rd_q;
  assign dbg_data    = (ZERO_R0 && (dbg_addr == '0)) ? '0 : regs_q[dbg_addr];
  assign wr_cnt      = cnt_q;

endmodule

// File: tb/tb_regfile_resp.sv
// Scoreboard bench for regfile_resp: two instances (ZERO_R0=0 and 1) share the stimulus.
module tb_regfile_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_en;
  logic [3:0]  ld_addr;
  logic [15:0] ld_data;
  logic [3:0]  dbg_addr = 4'd0;
  logic [15:0] dbg_a, dbg_b;
  logic [7:0]  cnt_a, cnt_b;

  regfile_resp_if ia ();
  regfile_resp_if ib ();

  assign ib.cs      = ia.cs;
  assign ib.rw      = ia.rw;
  assign ib.address = ia.address;
  assign ib.memdatw = ia.memdatw;

  regfile_resp #(.ZERO_R0(1'b0)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .bus      (ia.slave),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_a),
    .wr_cnt   (cnt_a)
  );

  regfile_resp #(.ZERO_R0(1'b1)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .bus      (ib.slave),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_b),
    .wr_cnt   (cnt_b)
  );

  always #50 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard entry kinds: 0/1 memdatr A/B, 2/3 wr_cnt A/B, 4/5 dbg_data A/B.
  typedef struct {
    int unsigned when;
    int          sel;
    logic [3:0]  addr;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  ea = 8'd0;
  logic [7:0]  eb = 8'd0;

  exp_t        mon_e;
  logic [15:0] act;

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].when <= cyc) begin
      mon_e    = sb.pop_front();
      dbg_addr = mon_e.addr;
      #1;
      case (mon_e.sel)
        0:       act = ia.memdatr;
        1:       act = ib.memdatr;
        2:       act = {8'h00, cnt_a};
        3:       act = {8'h00, cnt_b};
        4:       act = dbg_a;
        default: act = dbg_b;
      endcase
      checks++;
      if (mon_e.when != cyc || act !== mon_e.val) begin
        errors++;
        $display("FAIL %s (cycle %0d, due %0d): got %h want %h",
                 mon_e.name, cyc, mon_e.when, act, mon_e.val);
      end
    end
  end

  task automatic push(int sel, logic [3:0] a, logic [15:0] v, string nm);
    exp_t e;
    e.when = cyc + 1;
    e.sel  = sel;
    e.addr = a;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic push_cnt(string nm);
    push(2, 4'd0, {8'h00, ea}, {nm, "_cnt_a"});
    push(3, 4'd0, {8'h00, eb}, {nm, "_cnt_b"});
  endtask

  task automatic drive(bit c, bit r, logic [3:0] a, logic [15:0] w,
                       bit le, logic [3:0] la, logic [15:0] ld);
    ia.cs      = c;
    ia.rw      = r;
    ia.address = a;
    ia.memdatw = w;
    ld_en      = le;
    ld_addr    = la;
    ld_data    = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    tick();
    tick();
    rst = 1'b0;

    // Preload, then read r3 so memdatr is non-zero before reset.
    drive(0, 0, 4'd0, 16'h0, 1, 4'd3, 16'h1234); ea++; eb++; tick();
    drive(0, 0, 4'd0, 16'h0, 1, 4'd5, 16'hBEEF); ea++; eb++; tick();
    drive(0, 0, 4'd0, 16'h0, 1, 4'd2, 16'h00FF); ea++; eb++; tick();
    drive(1, 1, 4'd3, 16'h0, 0, 4'd0, 16'h0);
    push(0, 4'd0, 16'h1234, "pre_rd_a");
    push_cnt("preload");
    tick();

    // Reset with a write in flight on both ports: nothing may commit.
    rst = 1'b1;
    drive(1, 0, 4'd6, 16'h6666, 1, 4'd8, 16'h8888);
    ea = 8'd0; eb = 8'd0;
    push(0, 4'd0, 16'h0, "rst_rd_a");
    push(1, 4'd0, 16'h0, "rst_rd_b");
    push_cnt("rst");
    for (int i = 0; i < 16; i++) push(4, 4'(i), 16'h0, "rst_dbg_a");
    push(5, 4'd3, 16'h0, "rst_dbg_b3");
    tick();
    rst = 1'b0;

    // Read latency and pipelining.
    drive(0, 0, 4'd0, 16'h0, 1, 4'd3, 16'h1234); ea++; eb++; tick();
    drive(0, 0, 4'd0, 16'h0, 1, 4'd5, 16'hBEEF); ea++; eb++; tick();
    drive(1, 1, 4'd3, 16'h0, 0, 4'd0, 16'h0);
    push(0, 4'd0, 16'h1234, "rd_n_a");
    push(1, 4'd0, 16'h1234, "rd_n_b");
    tick();
    drive(1, 1, 4'd5, 16'h0, 0, 4'd0, 16'h0);
    push(0, 4'd0, 16'hBEEF, "rd_n1_a");
    push(1, 4'd0, 16'hBEEF, "rd_n1_b");
    tick();
    drive(0, 1, 4'd3, 16'h0, 0, 4'd0, 16'h0);
    push(0, 4'd0, 16'hBEEF, "rd_hold_a");
    tick();

    // Multi-cycle protocol write: last write wins, each cycle counts.
    drive(1, 0, 4'd7, 16'hAAAA, 0, 4'd0, 16'h0); ea++; eb++;
    push(4, 4'd7, 16'hAAAA, "mw1_r7");
    push_cnt("mw1");
    tick();
    drive(1, 0, 4'd7, 16'h0042, 0, 4'd0, 16'h0); ea++; eb++;
    push(4, 4'd7, 16'h0042, "mw2_r7");
    push_cnt("mw2");
    tick();
    drive(0, 0, 4'd7, 16'hFFFF, 0, 4'd0, 16'h0);
    push(4, 4'd7, 16'h0042, "cs0_r7");
    push(0, 4'd0, 16'hBEEF, "cs0_rd_a");
    push_cnt("cs0");
    tick();

    // Collisions.
    drive(1, 0, 4'd9, 16'h1111, 1, 4'd9, 16'h2222); ea++; eb++;
    push(4, 4'd9, 16'h2222, "col_same_r9");
    push_cnt("col_same");
    tick();
    drive(1, 0, 4'd9, 16'h1111, 1, 4'd10, 16'h2222); ea += 2; eb += 2;
    push(4, 4'd9, 16'h1111, "col_diff_r9");
    push(4, 4'd10, 16'h2222, "col_diff_r10");
    push(5, 4'd9, 16'h1111, "col_diff_r9_b");
    push_cnt("col_diff");
    tick();

    // Read and load to the same register on one edge: read sees the old value.
    drive(0, 0, 4'd0, 16'h0, 1, 4'd4, 16'h0001); ea++; eb++; tick();
    drive(1, 1, 4'd4, 16'h0, 1, 4'd4, 16'h0002); ea++; eb++;
    push(0, 4'd0, 16'h0001, "rbw_rd_a");
    push(1, 4'd0, 16'h0001, "rbw_rd_b");
    push(4, 4'd4, 16'h0002, "rbw_dbg_a");
    push_cnt("rbw");
    tick();

    // Register 0: writable on A, hard-wired zero on B.
    drive(1, 0, 4'd0, 16'h5555, 1, 4'd0, 16'h5555); ea++;
    push(4, 4'd0, 16'h5555, "r0_dbg_a");
    push(5, 4'd0, 16'h0000, "r0_dbg_b");
    push_cnt("r0_both");
    tick();
    drive(1, 0, 4'd0, 16'h5555, 1, 4'd1, 16'h7777); ea += 2; eb++;
    push(5, 4'd1, 16'h7777, "r0_r1_dbg_b");
    push_cnt("r0_r1");
    tick();
    drive(1, 1, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    push(0, 4'd0, 16'h5555, "r0_rd_a");
    push(1, 4'd0, 16'h0000, "r0_rd_b");
    tick();

    // 256 load writes to r1: both counters pass through 255 -> 0 and return.
    for (int i = 0; i < 256; i++) begin
      drive(0, 0, 4'd0, 16'h0, 1, 4'd1, 16'(i)); ea++; eb++;
      push_cnt("wrap");
      tick();
    end
    drive(0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    push(4, 4'd1, 16'h00FF, "wrap_r1_a");
    tick();

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_resp.md
Name: regfile_resp

Overview:
- Responder side of the controller's register-access interface (address/cs/rw/memdatw/memdatr).
- Holds the 16 x 16-bit general register file that the instruction controller reads operands from and writes results back to.
- Provides registered reads with 1-cycle latency, matching the controller's fetch timing: it drives an address on cycle N and samples memdatr on cycle N+2 edge.
- Adds a testbench/boot load port and a debug read port.

Parameters:
- DW, 16, data width of each register.
- AW, 4, address width; DEPTH = 2**AW registers.
- ZERO_R0, 0, when 1, register 0 reads as 0 and ignores all writes.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cs  in  1  chip select from controller.
- rw  in  1  1 = read, 0 = write; meaningful only when cs=1.
- address  in  AW  register index for protocol access.
- memdatw  in  DW  write data from controller.
- memdatr  out  DW  registered read data to controller.
- ld_en  in  1  load-port write strobe.
- ld_addr  in  AW  load-port register index.
- ld_data  in  DW  load-port write data.
- dbg_addr  in  AW  debug read index.
- dbg_data  out  DW  combinational debug read of regs[dbg_addr].
- wr_cnt  out  8  count of committed writes from either port; wraps modulo 256.

Behaviour:
- Reset is synchronous on the rst=1 clock edge:
  - all DEPTH registers cleared to 0;
  - memdatr=0, wr_cnt=0.
  - Reset mid-access discards that access; no write commits on a reset edge.
- Read: on an edge with cs=1, rw=1, memdatr <= regs[address].
  - The value is visible after that edge (latency 1).
  - The address may change on the very next cycle; the next read returns the new address one cycle later.
  - Back-to-back reads on consecutive cycles are fully pipelined.
- memdatr holds its last value on any edge without a read (cs=0, or rw=0).
- Protocol write: on every edge with cs=1, rw=0, regs[address] <= memdatw.
  - The controller holds cs=1/rw=0 for several cycles and updates memdatw only in the last one. The block therefore writes every qualifying cycle; the last write wins. This is required behaviour, not an error.
- Load write: on an edge with ld_en=1, regs[ld_addr] <= ld_data.
- Simultaneous protocol write and load write:
  - Same address: the load port wins.
  - Different addresses: both commit.
  - wr_cnt increments by the number of distinct commits (1 or 2).
- Protocol read together with a load write to the same address: read-before-write, so memdatr gets the old value.
- cs=0: no protocol access; address, rw and memdatw are ignored.
- ZERO_R0=1:
  - writes to index 0 are dropped and do not count in wr_cnt;
  - memdatr and dbg_data return 0 for index 0.
- dbg_data = regs[dbg_addr] combinationally; it reflects a write from the edge just taken.
- wr_cnt increments per committed write, wraps 255 -> 0, and is a plain counter with no saturation.
- Out-of-range addresses are impossible, since DEPTH = 2**AW.
- No X propagation: every register has a defined reset value.

Decomposition:
- Shared package (regfile_pkg):
  - DW, AW;
  - RW_READ=1'b1 and RW_WRITE=1'b0 encodings, for reuse by the controller and this block.
- No sub-module: the storage array, read register and counter fit in one module (~150 lines).
- The write-arbitration logic may be a local function.

Test Plan:
- Reset: preload regs via the load port, then pulse rst one cycle. Expect:
  - memdatr=0, wr_cnt=0;
  - dbg_data=0 for all 16 addresses.
- Read latency:
  - Setup: ld r3=0x1234 and r5=0xBEEF.
  - Stimulus: cs=1, rw=1, address=3 on cycle N, then address=5 on cycle N+1.
  - Expect memdatr=0x1234 after the N edge and 0xBEEF after the N+1 edge.
- Multi-cycle write:
  - Stimulus: cs=1, rw=0, address=7 for 2 cycles, with memdatw=0xAAAA then 0x0042.
  - Expect r7=0x0042 and wr_cnt=2.
  - Then cs=0 with memdatw=0xFFFF: r7 unchanged.
- Collisions:
  - Protocol write 0x1111 and load 0x2222 both to r9 on the same edge: expect r9=0x2222, wr_cnt+1.
  - Same but load to r10: expect r9=0x1111, r10=0x2222, wr_cnt+2.
- Read/load same cycle:
  - Setup: r4=0x0001.
  - Stimulus: cs=1, rw=1, address=4 with ld r4=0x0002 on the same edge.
  - Expect memdatr=0x0001 and dbg_data(4)=0x0002.
- ZERO_R0=1 and counter wrap:
  - Write 0x5555 to r0 via both ports: expect r0 reads 0 and wr_cnt unchanged.
  - 256 writes to r1: expect wr_cnt wraps to 0.
